mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single-ported unified memory between the pipeline's instruction-fetch port and data (LWD/SWD) port. Memory has a fixed access latency. The block grants one access at a time and times the access with a latency counter. It returns one-cycle ready pulses to each requester and drives memory stall signals that the hazard control logic ORs into pc_write/ir_write/stall_IFID. Fetch accesses are abortable on branch/jump misprediction flush; writes are never aborted.

Parameters:
WORD_SIZE, 16, width of address and data buses
MEM_LATENCY, 2, cycles a command is held on the memory bus before read data is valid or a write is committed (legal range 1..15)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
i_readM  input  1  fetch request; held until i_ready or i_cancel
i_address  input  WORD_SIZE  fetch address
i_cancel  input  1  flush of in-flight fetch (flush_IFID)
i_data  output  WORD_SIZE  fetched word, valid only while i_ready=1
i_ready  output  1  one-cycle fetch completion pulse
d_readM  input  1  data read request; held until d_ready
d_writeM  input  1  data write request; held until d_ready; never together with d_readM
d_address  input  WORD_SIZE  data address
d_wdata  input  WORD_SIZE  store data
d_rdata  output  WORD_SIZE  load data, valid only while d_ready=1
d_ready  output  1  one-cycle data completion pulse
mem_readM  output  1  memory read command
mem_writeM  output  1  memory write command
mem_address  output  WORD_SIZE  memory address
mem_wdata  output  WORD_SIZE  memory write data
mem_rdata  input  WORD_SIZE  memory read data, valid in final cycle of a read
mem_stall_IF  output  1  i_readM && !i_ready
mem_stall_MEM  output  1  (d_readM||d_writeM) && !d_ready

Behaviour:
- States: IDLE, I_ACC, D_ACC. Counter cnt of width 4.
- Reset (async, any state): state=IDLE, cnt=0, latched op/address/wdata=0. All mem_* outputs and ready outputs are 0. An access in flight is dropped without a ready pulse.
- IDLE: if d_readM|d_writeM, latch the data op/address/wdata, go to D_ACC, and set cnt=MEM_LATENCY-1. Otherwise, if i_readM && !i_cancel, latch i_address, go to I_ACC, and set cnt=MEM_LATENCY-1. Data has priority.
- In I_ACC/D_ACC: mem_* outputs are driven from the latched registers, stable for exactly MEM_LATENCY cycles. cnt decrements each cycle while nonzero.
- Completion cycle (cnt==0): assert i_ready or d_ready combinationally, for exactly one cycle. i_data/d_rdata = mem_rdata for reads, and 0 otherwise.
- Back-to-back alternation in the completion cycle:
  - After a D completion: if i_readM && !i_cancel, go to I_ACC. Otherwise go to IDLE.
  - After an I completion: if a data request is pending, go to D_ACC. Otherwise go to IDLE.
  - The just-served requester is never re-granted in its own completion cycle, because it is still holding its request in that cycle.
- i_cancel in I_ACC, any cycle including completion: access aborted, i_ready stays 0, mem_readM drops next cycle, next state IDLE. i_cancel has no effect in D_ACC or IDLE.
- A fetch is never preempted by a later data request. A data request waits at most MEM_LATENCY cycles before grant.
- MEM_LATENCY=1: completion occurs in the first cycle of access. Back-to-back accesses give one access per cycle with no IDLE gap.
- Requests deasserted mid-access without cancel are a protocol violation. The access still completes and pulses ready.

Test Plan:
- MEM_LATENCY=2, i_readM with i_address=0x0010 and mem_rdata=0x6A01 -> mem_readM high 2 cycles at 0x0010; i_ready pulses 1 cycle with i_data=0x6A01; mem_stall_IF high until then.
- i_readM and d_writeM raised in the same cycle (d_address=0x0040, d_wdata=0xBEEF) -> write granted first; mem_writeM high 2 cycles; d_ready pulses; I_ACC begins the next cycle with no IDLE gap; i_ready 2 cycles later.
- i_cancel asserted in the 1st cycle of I_ACC -> no i_ready; mem_readM low the next cycle; a new fetch at 0x0020 is granted from IDLE.
- i_cancel during D_ACC (load at 0x0030, mem_rdata=0x1234) -> ignored; d_ready with d_rdata=0x1234.
- reset_n pulled low mid-D_ACC -> all outputs 0 immediately; after release, state is IDLE and no d_ready appears until re-request.
- MEM_LATENCY=1, continuous i_readM plus d_readM -> grants alternate D, I, D, I; one ready pulse per cycle.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle shared by the fetch port, the data port and the unified memory,
// all routed through mem_port_arbiter.
interface mem_port_arbiter_if #(
  parameter int WORD_SIZE = 16
);
  // Requesters raise i_readM / d_readM / d_writeM and hold them until the
  // matching *_ready pulse (fetch may instead withdraw with i_cancel).
  // *_ready is a one-cycle completion pulse; i_data/d_rdata are valid only then.
  logic                 i_readM;
  logic [WORD_SIZE-1:0] i_address;
  logic                 i_cancel;
  logic [WORD_SIZE-1:0] i_data;
  logic                 i_ready;
  logic                 d_readM;
  logic                 d_writeM;
  logic [WORD_SIZE-1:0] d_address;
  logic [WORD_SIZE-1:0] d_wdata;
  logic [WORD_SIZE-1:0] d_rdata;
  logic                 d_ready;
  logic                 mem_readM;
  logic                 mem_writeM;
  logic [WORD_SIZE-1:0] mem_address;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic                 mem_stall_IF;
  logic                 mem_stall_MEM;
  logic [1:0]           dbg_state;

  // Arbiter side.
  modport slave (
    input  i_readM, i_address, i_cancel, d_readM, d_writeM, d_address, d_wdata,
           mem_rdata,
    output i_data, i_ready, d_rdata, d_ready, mem_readM, mem_writeM,
           mem_address, mem_wdata, mem_stall_IF, mem_stall_MEM, dbg_state
  );

  // Requester/memory environment side.
  modport master (
    output i_readM, i_address, i_cancel, d_readM, d_writeM, d_address, d_wdata,
           mem_rdata,
    input  i_data, i_ready, d_rdata, d_ready, mem_readM, mem_writeM,
           mem_address, mem_wdata, mem_stall_IF, mem_stall_MEM, dbg_state
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and
// data access, timing each access with a fixed-latency down-counter.
module mem_port_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int MEM_LATENCY = 2
) (
  input logic               clk,
  input logic               reset_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_ACC = 2'd1,
    D_ACC = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t               state_q;
  logic [3:0]           cnt_q;
  logic                 op_wr_q;
  logic [WORD_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] wdata_q;

  logic d_req;
  logic busy;
  logic done;
  logic i_abort;
  logic take_d;
  logic take_i;

  assign d_req   = bus.d_readM | bus.d_writeM;
  assign busy    = (state_q != IDLE);
  assign done    = busy && (cnt_q == 4'd0);
  assign i_abort = (state_q == I_ACC) && bus.i_cancel;

  // Alternate grants: data may follow a completed fetch, fetch may follow a
  // completed data access; the just-served side is never re-granted.
  assign take_d = d_req && ((state_q == IDLE) ||
                            ((state_q == I_ACC) && done && !bus.i_cancel));
  assign take_i = bus.i_readM && !bus.i_cancel &&
                  (((state_q == IDLE) && !d_req) ||
                   ((state_q == D_ACC) && done));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (take_d) begin
      state_q <= D_ACC;
      cnt_q   <= CNT_INIT;
      op_wr_q <= bus.d_writeM;
      addr_q  <= bus.d_address;
      wdata_q <= bus.d_wdata;
    end else if (take_i) begin
      state_q <= I_ACC;
      cnt_q   <= CNT_INIT;
      op_wr_q <= 1'b0;
      addr_q  <= bus.i_address;
    end else if (done || i_abort) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else if (busy) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Memory command follows the latched access and is zero whenever idle.
  assign bus.mem_readM   = (state_q == I_ACC) || ((state_q == D_ACC) && !op_wr_q);
  assign bus.mem_writeM  = (state_q == D_ACC) && op_wr_q;
  assign bus.mem_address = busy ? addr_q : '0;
  assign bus.mem_wdata   = bus.mem_writeM ? wdata_q : '0;

  assign bus.i_ready = (state_q == I_ACC) && done && !bus.i_cancel;
  assign bus.d_ready = (state_q == D_ACC) && done;
  assign bus.i_data  = bus.i_ready ? bus.mem_rdata : '0;
  assign bus.d_rdata = (bus.d_ready && !op_wr_q) ? bus.mem_rdata : '0;

  assign bus.mem_stall_IF  = bus.i_readM && !bus.i_ready;
  assign bus.mem_stall_MEM = d_req && !bus.d_ready;
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at MEM_LATENCY=2 and MEM_LATENCY=1.
module tb_mem_port_arbiter;

  logic clk;
  logic reset_n;
  int   n_pass;
  int   n_total;

  mem_port_arbiter_if #(.WORD_SIZE(16)) bus2 ();
  mem_port_arbiter_if #(.WORD_SIZE(16)) bus1 ();

  mem_port_arbiter #(.WORD_SIZE(16), .MEM_LATENCY(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2)
  );
  mem_port_arbiter #(.WORD_SIZE(16), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // inputs change at the falling edge; outputs are sampled 1 ns later
  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    bus2.i_readM = 0; bus2.i_address = 0; bus2.i_cancel = 0;
    bus2.d_readM = 0; bus2.d_writeM = 0; bus2.d_address = 0; bus2.d_wdata = 0;
    bus2.mem_rdata = 0;
    bus1.i_readM = 0; bus1.i_address = 0; bus1.i_cancel = 0;
    bus1.d_readM = 0; bus1.d_writeM = 0; bus1.d_address = 0; bus1.d_wdata = 0;
    bus1.mem_rdata = 0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset_n = 1'b0;
    idle_inputs();
    step(); step();
    #1;
    chk("rst_mem_readM", 16'(bus2.mem_readM), 16'd0);
    chk("rst_i_ready",   16'(bus2.i_ready),   16'd0);
    chk("rst_d_ready",   16'(bus2.d_ready),   16'd0);
    chk("rst_state",     16'(bus2.dbg_state), 16'd0);
    step();
    reset_n = 1'b1;

    // plain fetch at 0x0010
    step();
    bus2.i_readM = 1; bus2.i_address = 16'h0010; bus2.mem_rdata = 16'h6A01;
    #1;
    chk("f_idle_readM", 16'(bus2.mem_readM),    16'd0);
    chk("f_idle_stall", 16'(bus2.mem_stall_IF), 16'd1);
    step(); #1;
    chk("f_c1_readM", 16'(bus2.mem_readM),    16'd1);
    chk("f_c1_addr",  bus2.mem_address,       16'h0010);
    chk("f_c1_ready", 16'(bus2.i_ready),      16'd0);
    chk("f_c1_stall", 16'(bus2.mem_stall_IF), 16'd1);
    step(); #1;
    chk("f_c2_readM", 16'(bus2.mem_readM),    16'd1);
    chk("f_c2_ready", 16'(bus2.i_ready),      16'd1);
    chk("f_c2_data",  bus2.i_data,            16'h6A01);
    chk("f_c2_stall", 16'(bus2.mem_stall_IF), 16'd0);
    step();
    bus2.i_readM = 0;
    #1;
    chk("f_after_readM", 16'(bus2.mem_readM), 16'd0);
    chk("f_after_ready", 16'(bus2.i_ready),   16'd0);

    // simultaneous write and fetch: write first, then fetch with no gap
    step();
    bus2.i_readM = 1; bus2.i_address = 16'h0050;
    bus2.d_writeM = 1; bus2.d_address = 16'h0040; bus2.d_wdata = 16'hBEEF;
    #1;
    chk("w_idle_stallM", 16'(bus2.mem_stall_MEM), 16'd1);
    step(); #1;
    chk("w_c1_writeM", 16'(bus2.mem_writeM), 16'd1);
    chk("w_c1_readM",  16'(bus2.mem_readM),  16'd0);
    chk("w_c1_addr",   bus2.mem_address,     16'h0040);
    chk("w_c1_wdata",  bus2.mem_wdata,       16'hBEEF);
    chk("w_c1_dready", 16'(bus2.d_ready),    16'd0);
    step(); #1;
    chk("w_c2_writeM", 16'(bus2.mem_writeM),    16'd1);
    chk("w_c2_dready", 16'(bus2.d_ready),       16'd1);
    chk("w_c2_rdata",  bus2.d_rdata,            16'h0000);
    chk("w_c2_stallM", 16'(bus2.mem_stall_MEM), 16'd0);
    step();
    bus2.d_writeM = 0;
    #1;
    chk("w_i1_state",  16'(bus2.dbg_state),  16'd1);
    chk("w_i1_readM",  16'(bus2.mem_readM),  16'd1);
    chk("w_i1_writeM", 16'(bus2.mem_writeM), 16'd0);
    chk("w_i1_addr",   bus2.mem_address,     16'h0050);
    chk("w_i1_iready", 16'(bus2.i_ready),    16'd0);
    step(); #1;
    chk("w_i2_iready", 16'(bus2.i_ready), 16'd1);
    chk("w_i2_idata",  bus2.i_data,       16'h6A01);
    step();
    bus2.i_readM = 0;

    // fetch cancelled in its first cycle, then a fresh fetch at 0x0020
    step();
    bus2.i_readM = 1; bus2.i_address = 16'h0060;
    step();
    bus2.i_cancel = 1;
    #1;
    chk("c_c1_readM", 16'(bus2.mem_readM), 16'd1);
    chk("c_c1_ready", 16'(bus2.i_ready),   16'd0);
    step();
    bus2.i_cancel = 0; bus2.i_address = 16'h0020;
    #1;
    chk("c_after_readM", 16'(bus2.mem_readM), 16'd0);
    chk("c_after_ready", 16'(bus2.i_ready),   16'd0);
    chk("c_after_state", 16'(bus2.dbg_state), 16'd0);
    step(); #1;
    chk("c_new_readM", 16'(bus2.mem_readM), 16'd1);
    chk("c_new_addr",  bus2.mem_address,    16'h0020);
    step(); #1;
    chk("c_new_ready", 16'(bus2.i_ready), 16'd1);
    step();
    bus2.i_readM = 0;

    // cancel has no effect on a data load
    step();
    bus2.d_readM = 1; bus2.d_address = 16'h0030; bus2.mem_rdata = 16'h1234;
    step();
    bus2.i_cancel = 1;
    #1;
    chk("l_c1_readM",  16'(bus2.mem_readM), 16'd1);
    chk("l_c1_addr",   bus2.mem_address,    16'h0030);
    chk("l_c1_dready", 16'(bus2.d_ready),   16'd0);
    step(); #1;
    chk("l_c2_dready", 16'(bus2.d_ready), 16'd1);
    chk("l_c2_rdata",  bus2.d_rdata,      16'h1234);
    chk("l_c2_iready", 16'(bus2.i_ready), 16'd0);
    step();
    bus2.d_readM = 0; bus2.i_cancel = 0;
    #1;
    chk("l_after_state", 16'(bus2.dbg_state), 16'd0);

    // reset in the middle of a data access
    step();
    bus2.d_readM = 1; bus2.d_address = 16'h0030;
    step(); #1;
    chk("r_pre_readM", 16'(bus2.mem_readM), 16'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("r_in_readM",  16'(bus2.mem_readM),   16'd0);
    chk("r_in_addr",   bus2.mem_address,      16'h0000);
    chk("r_in_dready", 16'(bus2.d_ready),     16'd0);
    chk("r_in_state",  16'(bus2.dbg_state),   16'd0);
    bus2.d_readM = 0;
    step();
    reset_n = 1'b1;
    #1;
    chk("r_rel_state", 16'(bus2.dbg_state), 16'd0);
    step(); #1;
    chk("r_post_dready", 16'(bus2.d_ready),   16'd0);
    chk("r_post_readM",  16'(bus2.mem_readM), 16'd0);
    chk("r_post_state",  16'(bus2.dbg_state), 16'd0);

    // MEM_LATENCY=1: continuous fetch and load alternate D, I, D, I
    step();
    bus1.i_readM = 1; bus1.i_address = 16'h0100;
    bus1.d_readM = 1; bus1.d_address = 16'h0200; bus1.mem_rdata = 16'h5555;
    #1;
    chk("a_idle_state", 16'(bus1.dbg_state), 16'd0);
    for (int k = 0; k < 2; k++) begin
      step(); #1;
      chk("a_d_dready", 16'(bus1.d_ready), 16'd1);
      chk("a_d_iready", 16'(bus1.i_ready), 16'd0);
      chk("a_d_addr",   bus1.mem_address,  16'h0200);
      chk("a_d_rdata",  bus1.d_rdata,      16'h5555);
      step(); #1;
      chk("a_i_iready", 16'(bus1.i_ready), 16'd1);
      chk("a_i_dready", 16'(bus1.d_ready), 16'd0);
      chk("a_i_addr",   bus1.mem_address,  16'h0100);
      chk("a_i_idata",  bus1.i_data,       16'h5555);
    end
    bus1.i_readM = 0; bus1.d_readM = 0;
    step(); #1;
    chk("a_end_state", 16'(bus1.dbg_state), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
